recovery_controller: RTL and testbench

- Rollback/replay controller for the fault-tolerant core, sitting directly upstream of the performance estimator.
- Consumes fault pulses from the lockstep/TMR comparator and the commit stream. Keeps a checkpoint of the last good committed PC.
- On a fault it sequences flush -> PC restore -> replay. Drives recovery_active, which the performance estimator counts as overhead cycles.
- Escalates to a sticky fatal state when retries are exhausted.

---
 rtl/recovery_controller.sv | 169 ++++++++++++++++
 tb/tb_recovery_controller.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/recovery_controller.sv
// Rollback/replay controller: checkpoints the last good committed PC and, on a
// comparator fault, sequences flush -> restore -> replay, escalating to a sticky fatal state.
module recovery_controller #(
  parameter int              XLEN           = 32,
  parameter logic [XLEN-1:0] RESET_PC       = '0,
  parameter int              FLUSH_CYCLES   = 4,
  parameter int              MAX_RETRIES    = 3,
  parameter int              REPLAY_TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            fault_detected,
  input  logic            commit_valid,
  input  logic [XLEN-1:0] commit_pc,
  input  logic            restore_ack,
  output logic            recovery_active,
  output logic            pipeline_flush,
  output logic            restore_valid,
  output logic [XLEN-1:0] restore_pc,
  output logic            fatal_error,
  output logic [31:0]     recovery_event_count
);

  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  localparam int TW = $clog2(REPLAY_TIMEOUT + 1);
  localparam int RW = $clog2(MAX_RETRIES + 1) + 1;

  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST    = TW'(REPLAY_TIMEOUT - 1);
  localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FLUSH   = 3'd1,
    RESTORE = 3'd2,
    REPLAY  = 3'd3,
    FATAL   = 3'd4
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [XLEN-1:0] checkpoint_r;
  logic [FW-1:0]   flush_cnt_r;
  logic [TW-1:0]   timeout_cnt_r;
  logic [RW-1:0]   retry_cnt_r;
  logic [31:0]     event_cnt_r;
  logic            fail_s;
  logic            clean_commit_s;

  // A fault outranks a same-cycle commit; the timeout is a failure in its own right.
  assign fail_s         = fault_detected || (timeout_cnt_r == TO_LAST);
  assign clean_commit_s = commit_valid && !fault_detected;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (fault_detected) state_nxt_s = FLUSH;
        else                state_nxt_s = IDLE;
      end
      FLUSH: begin
        if (flush_cnt_r == FLUSH_LAST) state_nxt_s = RESTORE;
        else                           state_nxt_s = FLUSH;
      end
      RESTORE: begin
        if (restore_ack) state_nxt_s = REPLAY;
        else             state_nxt_s = RESTORE;
      end
      REPLAY: begin
        if (fail_s) begin
          if (retry_cnt_r == RETRY_MAX) state_nxt_s = FATAL;
          else                          state_nxt_s = FLUSH;
        end else if (commit_valid) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = REPLAY;
        end
      end
      FATAL:   state_nxt_s = FATAL;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Checkpoint, attempt counters and event counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      checkpoint_r  <= RESET_PC;
      flush_cnt_r   <= '0;
      timeout_cnt_r <= '0;
      retry_cnt_r   <= '0;
      event_cnt_r   <= 32'd0;
    end else begin
      flush_cnt_r <= (state_r == FLUSH) ? flush_cnt_r + FW'(1) : '0;
      case (state_r)
        IDLE: begin
          if (clean_commit_s) checkpoint_r <= commit_pc;
          else                checkpoint_r <= checkpoint_r;
          if (fault_detected && (event_cnt_r != 32'hFFFF_FFFF)) event_cnt_r <= event_cnt_r + 32'd1;
          else                                                  event_cnt_r <= event_cnt_r;
        end
        RESTORE: begin
          if (restore_ack) timeout_cnt_r <= '0;
          else             timeout_cnt_r <= timeout_cnt_r;
        end
        REPLAY: begin
          timeout_cnt_r <= timeout_cnt_r + TW'(1);
          if (fail_s) begin
            if (retry_cnt_r != RETRY_MAX) retry_cnt_r <= retry_cnt_r + RW'(1);
            else                          retry_cnt_r <= retry_cnt_r;
          end else if (commit_valid) begin
            checkpoint_r <= commit_pc;
            retry_cnt_r  <= '0;
          end else begin
            retry_cnt_r <= retry_cnt_r;
          end
        end
        default: begin
          checkpoint_r <= checkpoint_r;
        end
      endcase
    end
  end

  // Moore output decode
  always_comb begin
    recovery_active = 1'b0;
    pipeline_flush  = 1'b0;
    restore_valid   = 1'b0;
    fatal_error     = 1'b0;
    restore_pc      = checkpoint_r;
    case (state_r)
      IDLE: begin
        recovery_active = 1'b0;
      end
      FLUSH: begin
        recovery_active = 1'b1;
        pipeline_flush  = 1'b1;
      end
      RESTORE: begin
        recovery_active = 1'b1;
        restore_valid   = 1'b1;
      end
      REPLAY: begin
        recovery_active = 1'b1;
      end
      FATAL: begin
        recovery_active = 1'b1;
        pipeline_flush  = 1'b1;
        fatal_error     = 1'b1;
      end
      default: begin
        recovery_active = 1'b0;
      end
    endcase
  end

  assign recovery_event_count = event_cnt_r;

endmodule

// File: tb/tb_recovery_controller.sv
// Directed-vector bench for recovery_controller with hand-computed expectations.
module tb_recovery_controller;

  logic        clk;
  logic        reset_n;
  logic        fault_detected;
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic        restore_ack;
  logic        recovery_active;
  logic        pipeline_flush;
  logic        restore_valid;
  logic [31:0] restore_pc;
  logic        fatal_error;
  logic [31:0] recovery_event_count;

  int n_vec;
  int n_miss;
  int act_cycles;

  recovery_controller dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .fault_detected       (fault_detected),
    .commit_valid         (commit_valid),
    .commit_pc            (commit_pc),
    .restore_ack          (restore_ack),
    .recovery_active      (recovery_active),
    .pipeline_flush       (pipeline_flush),
    .restore_valid        (restore_valid),
    .restore_pc           (restore_pc),
    .fatal_error          (fatal_error),
    .recovery_event_count (recovery_event_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (recovery_active) act_cycles++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_act"},   {31'd0, recovery_active}, 32'd0);
    check({tag, "_flush"}, {31'd0, pipeline_flush},  32'd0);
    check({tag, "_rv"},    {31'd0, restore_valid},   32'd0);
    check({tag, "_fatal"}, {31'd0, fatal_error},     32'd0);
    check({tag, "_rpc"},   restore_pc,               32'd0);
    check({tag, "_cnt"},   recovery_event_count,     32'd0);
  endtask

  task automatic do_reset();
    reset_n        = 1'b0;
    fault_detected = 1'b0;
    commit_valid   = 1'b0;
    commit_pc      = 32'd0;
    restore_ack    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Starting in the first FLUSH cycle: checks flush window and restore, then acks into REPLAY.
  task automatic run_to_replay(input string tag, input logic [31:0] exp_pc);
    for (int i = 0; i < 4; i++) begin
      check({tag, "_flush"}, {31'd0, pipeline_flush}, 32'd1);
      tick();
    end
    check({tag, "_rv"},  {31'd0, restore_valid}, 32'd1);
    check({tag, "_rpc"}, restore_pc, exp_pc);
    restore_ack = 1'b1;
    tick();
    restore_ack = 1'b0;
    check({tag, "_replay"}, {29'd0, recovery_active, pipeline_flush, restore_valid}, 32'd4);
  endtask

  task automatic inject_fault();
    fault_detected = 1'b1;
    tick();
    fault_detected = 1'b0;
  endtask

  task automatic commit(input logic [31:0] pc);
    commit_valid = 1'b1;
    commit_pc    = pc;
    tick();
    commit_valid = 1'b0;
  endtask

  initial begin
    n_vec      = 0;
    n_miss     = 0;
    act_cycles = 0;
    do_reset();
    check_reset_outputs("rst");

    // Basic recovery: checkpoint 0x100, fault, ack held, clean commit 0x104.
    commit(32'h100);
    act_cycles = 0;
    fault_detected = 1'b1;
    check("t1_idle_act", {31'd0, recovery_active}, 32'd0);
    tick();
    fault_detected = 1'b0;
    check("t1_cnt", recovery_event_count, 32'd1);
    run_to_replay("t1", 32'h100);
    tick();
    check("t1_replay2", {31'd0, recovery_active}, 32'd1);
    commit(32'h104);
    check("t1_idle", {31'd0, recovery_active}, 32'd0);
    check("t1_act_cycles", act_cycles, 32'd7);

    // Ack withheld for 10 cycles in RESTORE.
    inject_fault();
    for (int i = 0; i < 4; i++) tick();
    for (int i = 0; i < 10; i++) begin
      check("t2_rv_hold",  {31'd0, restore_valid}, 32'd1);
      check("t2_rpc_hold", restore_pc, 32'h104);
      tick();
    end
    check("t2_rv_still", {31'd0, restore_valid}, 32'd1);
    restore_ack = 1'b1;
    tick();
    restore_ack = 1'b0;
    check("t2_replay", {31'd0, restore_valid}, 32'd0);
    commit(32'h108);
    check("t2_idle", {31'd0, recovery_active}, 32'd0);
    check("t2_cnt", recovery_event_count, 32'd2);

    // Replay timeout then clean retry, then a fresh fault gets all three retries.
    inject_fault();
    run_to_replay("t3a", 32'h108);
    for (int i = 0; i < 63; i++) tick();
    check("t3_to_replay63", {31'd0, pipeline_flush}, 32'd0);
    tick();
    check("t3_to_flush", {31'd0, pipeline_flush}, 32'd1);
    run_to_replay("t3b", 32'h108);
    commit(32'h10C);
    check("t3_idle", {31'd0, recovery_active}, 32'd0);
    inject_fault();
    for (int a = 0; a < 3; a++) begin
      run_to_replay("t3c", 32'h10C);
      inject_fault();
      check("t3_retry_fatal", {31'd0, fatal_error}, 32'd0);
    end
    run_to_replay("t3d", 32'h10C);
    commit(32'h110);
    check("t3_recovered", {31'd0, recovery_active}, 32'd0);
    check("t3_cnt", recovery_event_count, 32'd4);

    // Four failing windows from reset -> FATAL, sticky under random traffic.
    do_reset();
    commit(32'h300);
    inject_fault();
    for (int a = 0; a < 4; a++) begin
      check("t4_not_fatal", {31'd0, fatal_error}, 32'd0);
      run_to_replay("t4", 32'h300);
      inject_fault();
    end
    check("t4_fatal", {28'd0, fatal_error, recovery_active, pipeline_flush, restore_valid}, 32'hE);
    for (int i = 0; i < 100; i++) begin
      fault_detected = 1'($urandom_range(1, 0));
      commit_valid   = 1'($urandom_range(1, 0));
      commit_pc      = $urandom;
      restore_ack    = 1'($urandom_range(1, 0));
      tick();
      if (i % 10 == 9) begin
        check("t4_sticky", {28'd0, fatal_error, recovery_active, pipeline_flush, restore_valid}, 32'hE);
      end
    end
    fault_detected = 1'b0;
    commit_valid   = 1'b0;
    restore_ack    = 1'b0;
    check("t4_cnt", recovery_event_count, 32'd1);

    // Asynchronous reset out of FATAL, between clock edges.
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("t6_fatal_rst");
    reset_n = 1'b1;
    tick();

    // Fault with simultaneous commit: checkpoint must not take 0x200.
    commit(32'h180);
    fault_detected = 1'b1;
    commit_valid   = 1'b1;
    commit_pc      = 32'h200;
    tick();
    fault_detected = 1'b0;
    commit_valid   = 1'b0;
    check("t5_flush", {31'd0, pipeline_flush}, 32'd1);
    run_to_replay("t5", 32'h180);
    commit(32'h184);

    // Asynchronous reset during FLUSH.
    inject_fault();
    tick();
    check("t6_in_flush", {31'd0, pipeline_flush}, 32'd1);
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("t6_flush_rst");
    reset_n = 1'b1;
    tick();
    check("t6_idle_after", {31'd0, recovery_active}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
